// File: rtl/camara_captura_if.sv
// Camera byte bus into the capture stage and the frame-buffer write port out of it.
interface camara_captura_if #(
    parameter int ADDR_W = 15
);
    logic              Vsync;
    logic              Href;
    logic              Pclk;
    logic [7:0]        Imagen;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_done;
    logic              overflow;

    modport master (
        output Vsync, Href, Pclk, Imagen,
        input  wr_en, wr_addr, wr_data, frame_done, overflow
    );

    modport slave (
        input  Vsync, Href, Pclk, Imagen,
        output wr_en, wr_addr, wr_data, frame_done, overflow
    );
endinterface

// File: rtl/camara_captura.sv
// Samples the asynchronous camera bus, pairs RGB565 bytes into pixels and
// writes them as RGB332 to a linearly addressed frame buffer.
module camara_captura #(
    parameter int H_PIX  = 160,
    parameter int V_LIN  = 120,
    parameter int ADDR_W = 15
) (
    input  logic clk,
    input  logic rst,
    camara_captura_if.slave bus
);
    localparam int NPIX = H_PIX * V_LIN;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

    typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE} state_t;

    function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:5], hi[2:0], lo[4:3]};
    endfunction

    logic       pclk_p0, pclk_p1, pclk_p2;
    logic       href_p0, href_p1, href_p2;
    logic       vsync_p0, vsync_p1, vsync_p2;
    logic       pstb_p2, vrise_p2, vfall_p2;
    logic [7:0] imagen_p0, imagen_p1, byte_p2;

    state_t            state, state_nx;
    logic              phase, phase_nx;
    logic [7:0]        hi, hi_nx;
    logic [ADDR_W-1:0] waddr, waddr_nx;
    logic              full, full_nx;
    logic              ovf, ovf_nx;
    logic              wen, wen_nx;
    logic [7:0]        wdata, wdata_nx;
    logic              fdone, fdone_nx;

    // Stages p0/p1: two-flop synchronizer; p2: edge strobes with aligned data
    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_p0  <= 1'b0; pclk_p1  <= 1'b0; pclk_p2  <= 1'b0;
            href_p0  <= 1'b0; href_p1  <= 1'b0; href_p2  <= 1'b0;
            vsync_p0 <= 1'b0; vsync_p1 <= 1'b0; vsync_p2 <= 1'b0;
            pstb_p2  <= 1'b0; vrise_p2 <= 1'b0; vfall_p2 <= 1'b0;
        end else begin
            pclk_p0  <= bus.Pclk;  pclk_p1  <= pclk_p0;  pclk_p2  <= pclk_p1;
            href_p0  <= bus.Href;  href_p1  <= href_p0;  href_p2  <= href_p1;
            vsync_p0 <= bus.Vsync; vsync_p1 <= vsync_p0; vsync_p2 <= vsync_p1;
            pstb_p2  <= pclk_p1 & ~pclk_p2;
            vrise_p2 <= vsync_p1 & ~vsync_p2;
            vfall_p2 <= ~vsync_p1 & vsync_p2;
        end
    end

    always_ff @(posedge clk) begin
        imagen_p0 <= bus.Imagen;
        imagen_p1 <= imagen_p0;
        byte_p2   <= imagen_p1;
        hi        <= hi_nx;
    end

    // Capture FSM and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            phase <= 1'b0;
            waddr <= '0;
            full  <= 1'b0;
            ovf   <= 1'b0;
            wen   <= 1'b0;
            wdata <= 8'h00;
            fdone <= 1'b0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            waddr <= waddr_nx;
            full  <= full_nx;
            ovf   <= ovf_nx;
            wen   <= wen_nx;
            wdata <= wdata_nx;
            fdone <= fdone_nx;
        end
    end

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        hi_nx    = hi;
        waddr_nx = waddr;
        full_nx  = full;
        ovf_nx   = ovf;
        wen_nx   = 1'b0;
        wdata_nx = wdata;
        fdone_nx = 1'b0;
        // Address advances the cycle after its strobe, so wr_addr is pre-increment
        if (wen && (waddr != LAST))
            waddr_nx = waddr + ADDR_W'(1);
        case (state)
            IDLE: begin
                if (vrise_p2) begin
                    state_nx = VBLANK;
                    phase_nx = 1'b0;
                end
            end
            VBLANK: begin
                if (vfall_p2) begin
                    state_nx = ACTIVE;
                    waddr_nx = '0;
                    full_nx  = 1'b0;
                    ovf_nx   = 1'b0;
                    phase_nx = 1'b0;
                end
            end
            ACTIVE: begin
                if (!href_p2) begin
                    phase_nx = 1'b0;
                end else if (pstb_p2) begin
                    phase_nx = ~phase;
                    if (!phase) begin
                        hi_nx = byte_p2;
                    end else if (full) begin
                        ovf_nx = 1'b1;
                    end else begin
                        wen_nx   = 1'b1;
                        wdata_nx = rgb565_to_332(hi, byte_p2);
                        if (waddr == LAST)
                            full_nx = 1'b1;
                    end
                end
                if (vrise_p2) begin
                    fdone_nx = 1'b1;
                    phase_nx = 1'b0;
                    state_nx = VBLANK;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.wr_en      = wen;
    assign bus.wr_addr    = waddr;
    assign bus.wr_data    = wdata;
    assign bus.frame_done = fdone;
    assign bus.overflow   = ovf;
endmodule

// File: tb/tb_camara_captura.sv
// Directed bench for camara_captura on a 4x2 frame; a queue-based scoreboard
// checks every frame-buffer write as the DUT issues it.
module tb_camara_captura;
    localparam int H_PIX  = 4;
    localparam int V_LIN  = 2;
    localparam int ADDR_W = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    camara_captura_if #(.ADDR_W(ADDR_W)) bus ();

    camara_captura #(.H_PIX(H_PIX), .V_LIN(V_LIN), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   rise_cyc = 0;
    int   fd_cnt = 0;
    int   exp_fd = 0;
    logic prev_wen = 1'b0;

    // Hand-computed RGB565 -> RGB332 vectors
    logic [7:0] hi_t [8] = '{8'hF8, 8'h07, 8'h00, 8'hFF, 8'hA5, 8'h12, 8'hC3, 8'h6E};
    logic [7:0] lo_t [8] = '{8'h1F, 8'hE0, 8'h00, 8'hFF, 8'h5A, 8'h34, 8'h08, 8'hF1};
    logic [7:0] ex_t [8] = '{8'hE3, 8'h1C, 8'h00, 8'hFF, 8'hB7, 8'h0A, 8'hCD, 8'h7A};

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every write strobe
    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) fd_cnt++;
        if (bus.wr_en === 1'b1) begin
            chk("wr_en_gap", 32'(prev_wen), 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_write_addr", 32'(bus.wr_addr), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                chk("wr_data", 32'(bus.wr_data), 32'(e.data));
                chk("wr_latency", 32'(cyc - rise_cyc), 32'd3);
            end
        end
        prev_wen = bus.wr_en;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.Imagen = b;
        @(negedge clk);
        bus.Pclk = 1'b1;
        rise_cyc = cyc + 1;
        repeat (3) @(negedge clk);
        bus.Pclk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_pix(input logic [7:0] h, input logic [7:0] l,
                            input bit wr, input int addr, input logic [7:0] d);
        exp_t e;
        if (wr) begin
            e.addr = ADDR_W'(addr);
            e.data = d;
            q.push_back(e);
        end
        send_byte(h);
        send_byte(l);
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        bus.Vsync = 1'b1;
        repeat (4) @(negedge clk);
        bus.Vsync = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic line_on();
        @(negedge clk);
        bus.Href = 1'b1;
    endtask

    task automatic line_off();
        @(negedge clk);
        bus.Href = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.Vsync  = 1'b0;
        bus.Href   = 1'b1;
        bus.Pclk   = 1'b0;
        bus.Imagen = 8'h00;

        // Reset with the bus toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.Pclk   = ~bus.Pclk;
            bus.Vsync  = ~bus.Vsync;
            bus.Imagen = 8'($urandom);
        end
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        bus.Vsync = 1'b0; bus.Href = 1'b0; bus.Pclk = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single pixel after first Vsync pulse
        vsync_pulse();
        chk("fd_first_vsync", 32'(fd_cnt), 32'(exp_fd));
        line_on();
        send_pix(8'hF8, 8'h1F, 1'b1, 0, 8'hE3);
        line_off();
        chk("single_q_empty", 32'(q.size()), 32'd0);
        chk("single_addr_inc", 32'(bus.wr_addr), 32'd1);

        // Full 4x2 frame
        vsync_pulse();
        exp_fd++;
        chk("fd_after_single", 32'(fd_cnt), 32'(exp_fd));
        chk("frame_start_addr", 32'(bus.wr_addr), 32'd0);
        for (int ln = 0; ln < V_LIN; ln++) begin
            line_on();
            for (int p = 0; p < H_PIX; p++) begin
                int k;
                k = ln * H_PIX + p;
                send_pix(hi_t[k], lo_t[k], 1'b1, k, ex_t[k]);
            end
            line_off();
        end
        chk("full_q_empty", 32'(q.size()), 32'd0);
        chk("full_overflow", 32'(bus.overflow), 32'd0);
        chk("full_addr_hold", 32'(bus.wr_addr), 32'd7);
        vsync_pulse();
        exp_fd++;
        chk("fd_full_frame", 32'(fd_cnt), 32'(exp_fd));
        line_on();
        send_pix(8'hA5, 8'h5A, 1'b1, 0, 8'hB7);

        // Odd byte then Href drop
        send_pix(8'hF8, 8'h1F, 1'b1, 1, 8'hE3);
        send_byte(8'hAA);
        line_off();
        line_on();
        send_pix(8'h07, 8'hE0, 1'b1, 2, 8'h1C);
        line_off();
        chk("odd_q_empty", 32'(q.size()), 32'd0);

        // Overflow: three lines into a two-line frame
        vsync_pulse();
        exp_fd++;
        chk("fd_odd_frame", 32'(fd_cnt), 32'(exp_fd));
        for (int ln = 0; ln < 3; ln++) begin
            line_on();
            for (int p = 0; p < H_PIX; p++) begin
                int k;
                k = ln * H_PIX + p;
                send_pix(hi_t[k % 8], lo_t[k % 8], k < 8, k, ex_t[k % 8]);
            end
            line_off();
            if (ln == 1) chk("ovf_before", 32'(bus.overflow), 32'd0);
        end
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        chk("ovf_addr_hold", 32'(bus.wr_addr), 32'd7);
        chk("ovf_q_empty", 32'(q.size()), 32'd0);
        vsync_pulse();
        exp_fd++;
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);
        chk("ovf_next_addr", 32'(bus.wr_addr), 32'd0);
        chk("fd_ovf_frame", 32'(fd_cnt), 32'(exp_fd));

        // Mid-frame reset after pixel 3
        line_on();
        for (int p = 0; p < 3; p++) send_pix(hi_t[p], lo_t[p], 1'b1, p, ex_t[p]);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_addr", 32'(bus.wr_addr), 32'd0);
        chk("midrst_data", 32'(bus.wr_data), 32'd0);
        send_pix(8'h12, 8'h34, 1'b0, 0, 8'h00);
        send_pix(8'hC3, 8'h08, 1'b0, 0, 8'h00);
        line_off();
        vsync_pulse();
        chk("fd_after_midrst", 32'(fd_cnt), 32'(exp_fd));
        line_on();
        send_pix(8'h6E, 8'hF1, 1'b1, 0, 8'h7A);
        line_off();

        repeat (10) @(negedge clk);
        chk("final_q_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
